fdc_meas_sequencer: RTL and testbench

Measurement sequencer for the FDC core. It clears the core, holds the frequency-select line, and counts a programmable gate of reference-clock periods. It then captures the core's 5-bit count after a stability check and accumulates 2^AVG_LOG2 samples, presenting the sum through a valid/ready handshake. It sits between the top-level pin wrapper and the FDC core, and drives the core's reset and select inputs.

---
 rtl/fdc_meas_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_fdc_meas_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_meas_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fdc_meas_sequencer
//
// Measurement sequencer for the FDC core. For each sample it holds the core in
// reset, releases it, counts a programmable gate of reference-clock periods,
// waits for the core's 5-bit count to settle, and adds that count to an
// accumulator. After 2^AVG_LOG2 samples the sum is presented through a
// valid/ready handshake. Continuous mode restarts automatically after each
// accepted result.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   start           one-shot measurement request (sampled only in IDLE)
//   cont            continuous mode: restart after each accepted result
//   sel_in          select value latched at start, driven on fdc_selec
//   gate_len        gate length in clk_ref rising edges (0 behaves as 1)
//   clk_ref         reference clock, asynchronous to clk
//   fdc_out         FDC core count, asynchronous to clk
//   fdc_reset       active-high reset to the FDC core
//   fdc_selec       select to the FDC core
//   busy            high whenever the sequencer is not IDLE
//   result          raw sum of the samples (5+AVG_LOG2 bits)
//   result_valid    result available
//   result_ready    consumer accepts result
//   err_tmo         sticky: a sample timed out waiting for a stable count
// -----------------------------------------------------------------------------
module fdc_meas_sequencer #(
  parameter int CLR_CYCLES  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AVG_LOG2    = 2,
  parameter int TMO_CYCLES  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  sel_in,
  input  logic [7:0]            gate_len,
  input  logic                  clk_ref,
  input  logic [4:0]            fdc_out,
  output logic                  fdc_reset,
  output logic                  fdc_selec,
  output logic                  busy,
  output logic [5+AVG_LOG2-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  err_tmo
);

  localparam int RW  = 5 + AVG_LOG2;
  localparam int SCW = AVG_LOG2 + 1;
  localparam int CCW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int TCW = $clog2(TMO_CYCLES + 1);
  localparam int FSW = 5 * SYNC_STAGES;

  localparam logic [SCW-1:0] NSAMP      = SCW'(1 << AVG_LOG2);
  localparam logic [CCW-1:0] CLR_LAST   = CCW'(CLR_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(TMO_CYCLES - 1);
  // The stability check only counts once the synchroniser and the compare
  // register both hold values sampled after the gate closed.
  localparam logic [TCW-1:0] SETTLE_MIN = TCW'(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ARM    = 3'd2,
    S_GATE   = 3'd3,
    S_SETTLE = 3'd4,
    S_ACCUM  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d;
  logic                 ref_prev_q, ref_prev_d;
  logic [FSW-1:0]       fdc_sync_q, fdc_sync_d;
  logic [4:0]           fdc_cmp_q, fdc_cmp_d;
  logic                 sel_q, sel_d;
  logic [7:0]           gate_q, gate_d;
  logic [7:0]           edge_cnt_q, edge_cnt_d;
  logic [CCW-1:0]       clr_cnt_q, clr_cnt_d;
  logic [TCW-1:0]       settle_cnt_q, settle_cnt_d;
  logic [4:0]           cap_q, cap_d;
  logic [RW-1:0]        acc_q, acc_d;
  logic [SCW-1:0]       smp_cnt_q, smp_cnt_d;
  logic                 fdc_reset_q, fdc_reset_d;
  logic                 busy_q, busy_d;
  logic [RW-1:0]        result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic                 err_tmo_q, err_tmo_d;

  logic                 ref_rise;
  logic [4:0]           fdc_sync_last;
  logic [RW-1:0]        acc_sum;
  logic [SCW-1:0]       smp_next;
  logic [7:0]           edge_next;

  assign ref_rise      = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
  assign fdc_sync_last = fdc_sync_q[FSW-1 -: 5];
  assign acc_sum       = acc_q + RW'(cap_q);
  assign smp_next      = smp_cnt_q + SCW'(1'b1);
  assign edge_next     = edge_cnt_q + 8'd1;

  // Next-state and datapath logic for the synchronisers and the sequencer.
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    gate_d         = gate_q;
    edge_cnt_d     = edge_cnt_q;
    clr_cnt_d      = clr_cnt_q;
    settle_cnt_d   = settle_cnt_q;
    cap_d          = cap_q;
    acc_d          = acc_q;
    smp_cnt_d      = smp_cnt_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    err_tmo_d      = err_tmo_q;

    // Synchronisers run continuously; the compare register lags the last stage.
    ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], clk_ref};
    ref_prev_d = ref_sync_q[SYNC_STAGES-1];
    fdc_sync_d = {fdc_sync_q[FSW-6:0], fdc_out};
    fdc_cmp_d  = fdc_sync_last;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d     = sel_in;
          gate_d    = (gate_len == 8'd0) ? 8'd1 : gate_len;
          acc_d     = '0;
          smp_cnt_d = '0;
          clr_cnt_d = '0;
          err_tmo_d = 1'b0;
          state_d   = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d = S_ARM;
        end else begin
          clr_cnt_d = clr_cnt_q + CCW'(1'b1);
        end
      end

      // Wait for a reference edge so the gate always spans whole periods.
      S_ARM: begin
        if (ref_rise) begin
          edge_cnt_d = 8'd0;
          state_d    = S_GATE;
        end else begin
          state_d = S_ARM;
        end
      end

      S_GATE: begin
        if (ref_rise) begin
          edge_cnt_d = edge_next;
          if (edge_next == gate_q) begin
            settle_cnt_d = '0;
            state_d      = S_SETTLE;
          end else begin
            state_d = S_GATE;
          end
        end else begin
          state_d = S_GATE;
        end
      end

      // Capture once two consecutive post-gate samples agree; on timeout
      // take whatever is present and flag it.
      S_SETTLE: begin
        if ((settle_cnt_q >= SETTLE_MIN) && (fdc_sync_last == fdc_cmp_q)) begin
          cap_d   = fdc_sync_last;
          state_d = S_ACCUM;
        end else if (settle_cnt_q == TMO_LAST) begin
          cap_d     = fdc_sync_last;
          err_tmo_d = 1'b1;
          state_d   = S_ACCUM;
        end else begin
          settle_cnt_d = settle_cnt_q + TCW'(1'b1);
        end
      end

      S_ACCUM: begin
        acc_d     = acc_sum;
        smp_cnt_d = smp_next;
        if (smp_next == NSAMP) begin
          result_d       = acc_sum;
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end else begin
          clr_cnt_d = '0;
          state_d   = S_CLEAR;
        end
      end

      // Result is held until accepted; continuous mode restarts with the
      // latched select and gate length.
      S_DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          if (cont) begin
            acc_d     = '0;
            smp_cnt_d = '0;
            clr_cnt_d = '0;
            err_tmo_d = 1'b0;
            state_d   = S_CLEAR;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    fdc_reset_d = (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ref_sync_q     <= '0;
      ref_prev_q     <= 1'b0;
      fdc_sync_q     <= '0;
      fdc_cmp_q      <= 5'd0;
      sel_q          <= 1'b0;
      gate_q         <= 8'd0;
      edge_cnt_q     <= 8'd0;
      clr_cnt_q      <= '0;
      settle_cnt_q   <= '0;
      cap_q          <= 5'd0;
      acc_q          <= '0;
      smp_cnt_q      <= '0;
      fdc_reset_q    <= 1'b1;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_tmo_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ref_sync_q     <= ref_sync_d;
      ref_prev_q     <= ref_prev_d;
      fdc_sync_q     <= fdc_sync_d;
      fdc_cmp_q      <= fdc_cmp_d;
      sel_q          <= sel_d;
      gate_q         <= gate_d;
      edge_cnt_q     <= edge_cnt_d;
      clr_cnt_q      <= clr_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      cap_q          <= cap_d;
      acc_q          <= acc_d;
      smp_cnt_q      <= smp_cnt_d;
      fdc_reset_q    <= fdc_reset_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_tmo_q      <= err_tmo_d;
    end
  end

  assign fdc_reset    = fdc_reset_q;
  assign fdc_selec    = sel_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err_tmo      = err_tmo_q;

endmodule

// File: tb/tb_fdc_meas_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for fdc_meas_sequencer (default parameters).
// A small core emulator drives fdc_out with a per-sample value each time
// fdc_reset is released; the expected result is the plain sum of those values.
module tb_fdc_meas_sequencer;

  localparam int CLR  = 4;
  localparam int SYNC = 2;
  localparam int AVG  = 2;
  localparam int TMO  = 64;
  localparam int NS   = 1 << AVG;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic       sel_in;
  logic [7:0] gate_len;
  logic       clk_ref = 1'b0;
  logic [4:0] fdc_out;
  logic       fdc_reset;
  logic       fdc_selec;
  logic       busy;
  logic [5+AVG-1:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       err_tmo;

  fdc_meas_sequencer #(
    .CLR_CYCLES(CLR), .SYNC_STAGES(SYNC), .AVG_LOG2(AVG), .TMO_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .sel_in(sel_in),
    .gate_len(gate_len), .clk_ref(clk_ref), .fdc_out(fdc_out),
    .fdc_reset(fdc_reset), .fdc_selec(fdc_selec), .busy(busy),
    .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // reference clock: period ref_per clk cycles, edges placed 3 ns after posedge
  int ref_per = 6;
  int ref_ph  = 0;
  initial begin
    forever begin
      @(posedge clk); #3;
      ref_ph = ref_ph + 1;
      if (ref_ph >= ref_per) ref_ph = 0;
      clk_ref = (ref_ph < ref_per / 2);
    end
  end

  // core emulator + fdc_reset run-length monitor
  logic [4:0] vals [4];
  bit   tog_mode = 1'b0;
  int   epoch = 0;
  int   hi_runs[$];
  int   lo_runs[$];
  initial begin
    int seen_epoch, hi_len, lo_len, fall_cnt;
    logic prev;
    seen_epoch = 0; hi_len = 0; lo_len = 0; fall_cnt = 0; prev = 1'b1;
    fdc_out = 5'd0;
    forever begin
      @(posedge clk); #1;
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        hi_len = 0; lo_len = 0; fall_cnt = 0;
        hi_runs.delete(); lo_runs.delete();
      end
      if (fdc_reset) begin
        if (!prev) begin lo_runs.push_back(lo_len); lo_len = 0; end
        hi_len = hi_len + 1;
      end else begin
        if (prev) begin
          hi_runs.push_back(hi_len); hi_len = 0;
          fdc_out = tog_mode ? 5'd3 : vals[fall_cnt % 4];
          fall_cnt = fall_cnt + 1;
        end else if (tog_mode) begin
          fdc_out = (fdc_out == 5'd3) ? 5'd4 : 5'd3;
        end
        lo_len = lo_len + 1;
      end
      prev = fdc_reset;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total_cnt = total_cnt + 1;
    if (act == exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total_cnt = total_cnt + 1;
    if (act >= lo && act <= hi) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic kick(input logic s, input logic [7:0] gl);
    @(negedge clk);
    sel_in = s; gate_len = gl; start = 1'b1; epoch = epoch + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for a result and check it, the gate/clear timing and the handshake.
  task automatic collect(input int exp_lo, input int exp_hi, input int exp_sel,
                         input int exp_err, input int g, input int per,
                         input int settle, input int hold,
                         input int busy_after, input bit bump);
    bit got;
    bit stable;
    int held;
    int budget;
    got = 1'b0;
    budget = NS * (CLR + g * per + per + settle + 10) + 50;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (result_valid) begin got = 1'b1; break; end
    end
    chk("valid_seen", int'(got), 1);
    chk_rng("result", int'(result), exp_lo, exp_hi);
    chk("busy_in_done", int'(busy), 1);
    chk("fdc_selec", int'(fdc_selec), exp_sel);
    chk("fdc_reset_in_done", int'(fdc_reset), 1);
    chk("err_tmo", int'(err_tmo), exp_err);
    chk("gate_count", lo_runs.size(), NS);
    foreach (lo_runs[i])
      chk_rng("gate_window", lo_runs[i], g * per + settle + 2, g * per + per + settle + 1);
    chk("clear_count", hi_runs.size(), NS);
    foreach (hi_runs[i]) chk("clear_len", hi_runs[i], CLR);
    held = int'(result);
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!result_valid || int'(result) != held) stable = 1'b0;
    end
    chk("hold_stable", int'(stable), 1);
    result_ready = 1'b1;
    if (bump) epoch = epoch + 1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("valid_drop", int'(result_valid), 0);
    chk("busy_after", int'(busy), busy_after);
    chk("result_kept", int'(result), held);
  endtask

  typedef struct {
    logic       sel;
    logic [7:0] glen;
    int         per;
    logic [4:0] val;
    int         hold;
    int         exp_res;
  } vec_t;
  vec_t vecs [5];

  initial begin
    int g, p, s, exp_sum;
    vecs[0] = '{1'b0, 8'd4, 6,  5'd7,  10, 28};
    vecs[1] = '{1'b1, 8'd0, 10, 5'd31, 0,  124};
    vecs[2] = '{1'b0, 8'd1, 4,  5'd0,  3,  0};
    vecs[3] = '{1'b1, 8'd8, 5,  5'd19, 1,  76};
    vecs[4] = '{1'b0, 8'd2, 8,  5'd16, 2,  64};

    rst_n = 1'b0; start = 1'b0; cont = 1'b0; sel_in = 1'b0;
    gate_len = 8'd0; result_ready = 1'b0;
    for (int k = 0; k < 4; k++) vals[k] = 5'd0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_fdc_reset", int'(fdc_reset), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_err", int'(err_tmo), 0);
    chk("rst_selec", int'(fdc_selec), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // table-driven one-shot measurements with a constant core count
    for (int i = 0; i < 5; i++) begin
      ref_per = vecs[i].per;
      for (int k = 0; k < 4; k++) vals[k] = vecs[i].val;
      repeat (2) @(negedge clk);
      kick(vecs[i].sel, vecs[i].glen);
      g = (vecs[i].glen == 8'd0) ? 1 : int'(vecs[i].glen);
      collect(vecs[i].exp_res, vecs[i].exp_res, int'(vecs[i].sel), 0, g,
              vecs[i].per, SYNC + 2, vecs[i].hold, 0, 1'b0);
    end

    // asynchronous reset in the middle of a gate
    ref_per = 6;
    for (int k = 0; k < 4; k++) vals[k] = 5'd9;
    kick(1'b1, 8'd8);
    repeat (20) @(negedge clk);
    chk("pre_rst_in_gate", int'(fdc_reset), 0);
    chk("pre_rst_result", int'(result), vecs[4].exp_res);
    rst_n = 1'b0;
    #1;
    chk("arst_fdc_reset", int'(fdc_reset), 1);
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(result_valid), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_selec", int'(fdc_selec), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_no_partial", int'(result_valid), 0);
    chk("arst_stays_idle", int'(busy), 0);

    // unstable core count: every sample times out
    ref_per = 4;
    tog_mode = 1'b1;
    kick(1'b0, 8'd2);
    collect(3 * NS, 4 * NS, 0, 1, 2, 4, TMO, 2, 0, 1'b0);
    tog_mode = 1'b0;
    chk("err_sticky_idle", int'(err_tmo), 1);
    for (int k = 0; k < 4; k++) vals[k] = 5'd5;
    kick(1'b0, 8'd2);
    chk("err_cleared_by_start", int'(err_tmo), 0);
    collect(20, 20, 0, 0, 2, 4, SYNC + 2, 1, 0, 1'b0);

    // continuous mode, select held, cont dropped during the second run
    ref_per = 5;
    vals[0] = 5'd3; vals[1] = 5'd6; vals[2] = 5'd9; vals[3] = 5'd12;
    cont = 1'b1;
    kick(1'b1, 8'd3);
    sel_in = 1'b0; gate_len = 8'd1;
    collect(30, 30, 1, 0, 3, 5, SYNC + 2, 4, 1, 1'b1);
    repeat (10) @(negedge clk);
    chk("cont_selec_mid", int'(fdc_selec), 1);
    chk("cont_busy_mid", int'(busy), 1);
    cont = 1'b0;
    collect(30, 30, 1, 0, 3, 5, SYNC + 2, 2, 0, 1'b0);
    repeat (5) @(negedge clk);
    chk("cont_off_idle", int'(busy), 0);

    // randomized runs against the summing model; mid-run input changes ignored
    for (int r = 0; r < 6; r++) begin
      p = int'($urandom_range(12, 4));
      g = int'($urandom_range(5, 0));
      s = int'($urandom_range(1, 0));
      exp_sum = 0;
      for (int k = 0; k < 4; k++) begin
        vals[k] = 5'($urandom_range(31, 0));
        exp_sum = exp_sum + int'(vals[k]);
      end
      ref_per = p;
      repeat (2) @(negedge clk);
      kick(s[0], 8'(g));
      sel_in = ~s[0];
      gate_len = 8'($urandom_range(200, 2));
      repeat (8) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      collect(exp_sum, exp_sum, s, 0, (g == 0) ? 1 : g, p, SYNC + 2,
              int'($urandom_range(4, 0)), 0, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
